whitening_tx: RTL

//  Byte-stream transmitter that self-synchronously whitens and serialises frames for the receive-side dewhitener.

---
 rtl/whitening_pkg.sv | 23 ++
 rtl/whitening_lfsr.sv | 36 +++
 rtl/whitening_tx.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/whitening_pkg.sv
// Shared types and constants for the whitening transmitter and its scrambler.
package whitening_pkg;

    // Transmit FSM states; ST_PRE is only reachable in builds with the preamble feature.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_DATA = 2'd2,
        ST_END  = 2'd3
    } state_t;

    localparam int LFSR_W         = 7;
    localparam int TAP_HI         = 6;
    localparam int TAP_LO         = 3;
    localparam int BIT_PERIOD_DEF = 50;
    localparam int CNT_W_DEF      = 16;

    // One self-synchronous scrambler output bit for data bit d against state s.
    function automatic logic whiten_bit(input logic d, input logic [LFSR_W-1:0] s);
        return d ^ s[TAP_HI] ^ s[TAP_LO];
    endfunction

endpackage

// File: rtl/whitening_lfsr.sv
// Self-synchronous 7-bit scrambler step. i_clear makes the current step see an
// all-zero state, so a frame's first bit can be scrambled on the same cycle the
// state is cleared. The scrambled bit is shifted in, which is what lets a
// receiver run the inverse with the same structure.
module whitening_lfsr
    import whitening_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_step,
    input  logic i_d,
    output logic o_out
);

    logic [LFSR_W-1:0] r_state;
    logic [LFSR_W-1:0] w_eff;

    // Effective state for this cycle and the scrambled output bit.
    always_comb begin
        w_eff = i_clear ? '0 : r_state;
        o_out = whiten_bit(i_d, w_eff);
    end

    // Advance on step, otherwise just commit any clear.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= '0;
        end else if (i_step) begin
            r_state <= {w_eff[LFSR_W-2:0], o_out};
        end else begin
            r_state <= w_eff;
        end
    end

endmodule

// File: rtl/whitening_tx.sv
// Whitening serial transmitter: accepts bytes on a valid/ready port, scrambles
// them and sends each bit LSB first for BIT_PERIOD clocks with trigger_out
// framing the data bits. A one-byte holding register lets consecutive bytes of
// a frame run without a gap.
// Optional feature: define WHITEN_PREAMBLE_EN to send an unwhitened PREAMBLE
// byte (flagged by preamble_out) before the first data bit of every frame.
//
// Handshake: a byte transfers on a posedge where tx_valid && tx_ready; tx_ready
// is registered and never depends on tx_valid; while tx_ready is low the
// source must hold tx_data/tx_last/tx_valid stable.
module whitening_tx
    import whitening_pkg::*;
#(
    parameter int BIT_PERIOD = BIT_PERIOD_DEF,
    parameter int CNT_W      = CNT_W_DEF
`ifdef WHITEN_PREAMBLE_EN
    ,
    parameter logic [7:0] PREAMBLE = 8'hAA
`endif
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       output_data,
    output logic       trigger_out,
    output logic       preamble_out,
    output logic       busy,
    output logic       done,
    output logic       underrun,
    output logic [1:0] dbg_state
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_period_cnt, w_period_nxt;
    logic [2:0]       r_bit_cnt, w_bit_nxt;
    logic [7:0]       r_shift, w_shift_nxt;
    logic             r_cur_last, w_cur_last_nxt;
    logic [7:0]       r_hold, w_hold_nxt;
    logic             r_hold_last, w_hold_last_nxt;
    logic             r_hold_valid, w_hold_valid_nxt;
    logic             r_tx_ready, w_ready_nxt;
    logic             r_out_data, w_out_nxt;
    logic             r_trigger, w_trig_nxt;
    logic             r_done, w_done_nxt;
    logic             r_underrun, w_underrun_nxt;
`ifdef WHITEN_PREAMBLE_EN
    logic             r_preamble, w_pre_nxt;
`endif

    logic       w_accept;
    logic       w_period_wrap;
    logic       w_next_avail;
    logic [7:0] w_next_byte;
    logic       w_next_last;
    logic       w_lfsr_clear;
    logic       w_lfsr_step;
    logic       w_lfsr_d;
    logic       w_lfsr_out;

    whitening_lfsr u_lfsr (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_clear (w_lfsr_clear),
        .i_step  (w_lfsr_step),
        .i_d     (w_lfsr_d),
        .o_out   (w_lfsr_out)
    );

    // Handshake and next-byte source; a byte arriving on the cycle it is needed bypasses the holding register.
    always_comb begin
        w_accept      = tx_valid & r_tx_ready;
        w_period_wrap = (r_period_cnt == CNT_W'(BIT_PERIOD - 1));
        w_next_avail  = r_hold_valid | w_accept;
        w_next_byte   = r_hold_valid ? r_hold : tx_data;
        w_next_last   = r_hold_valid ? r_hold_last : tx_last;
    end

    // Scrambler input: the bit that will be driven next; state reads as zero outside DATA.
    always_comb begin
        w_lfsr_clear = (r_state != ST_DATA);
        w_lfsr_d     = 1'b0;
        case (r_state)
            ST_IDLE: w_lfsr_d = tx_data[0];
`ifdef WHITEN_PREAMBLE_EN
            ST_PRE:  w_lfsr_d = r_shift[0];
`endif
            ST_DATA: w_lfsr_d = (r_bit_cnt == 3'd7) ? w_next_byte[0] : r_shift[1];
            default: w_lfsr_d = 1'b0;
        endcase
    end

    // Next state, counters, data registers and registered outputs.
    always_comb begin
        w_state_nxt      = r_state;
        w_period_nxt     = r_period_cnt;
        w_bit_nxt        = r_bit_cnt;
        w_shift_nxt      = r_shift;
        w_cur_last_nxt   = r_cur_last;
        w_hold_nxt       = r_hold;
        w_hold_last_nxt  = r_hold_last;
        w_hold_valid_nxt = r_hold_valid;
        w_out_nxt        = r_out_data;
        w_trig_nxt       = r_trigger;
        w_done_nxt       = 1'b0;
        w_underrun_nxt   = 1'b0;
        w_lfsr_step      = 1'b0;
        w_ready_nxt      = 1'b0;
`ifdef WHITEN_PREAMBLE_EN
        w_pre_nxt        = r_preamble;
`endif

        case (r_state)
            ST_IDLE: begin
                w_out_nxt  = 1'b0;
                w_trig_nxt = 1'b0;
                if (w_accept) begin
                    w_shift_nxt    = tx_data;
                    w_cur_last_nxt = tx_last;
                    w_period_nxt   = '0;
                    w_bit_nxt      = '0;
`ifdef WHITEN_PREAMBLE_EN
                    w_state_nxt    = ST_PRE;
                    w_out_nxt      = PREAMBLE[0];
                    w_pre_nxt      = 1'b1;
`else
                    w_state_nxt    = ST_DATA;
                    w_lfsr_step    = 1'b1;
                    w_out_nxt      = w_lfsr_out;
                    w_trig_nxt     = 1'b1;
`endif
                end
            end

`ifdef WHITEN_PREAMBLE_EN
            ST_PRE: begin
                if (w_accept) begin
                    w_hold_nxt       = tx_data;
                    w_hold_last_nxt  = tx_last;
                    w_hold_valid_nxt = 1'b1;
                end
                if (!w_period_wrap) begin
                    w_period_nxt = r_period_cnt + CNT_W'(1);
                end else begin
                    w_period_nxt = '0;
                    if (r_bit_cnt != 3'd7) begin
                        w_bit_nxt = r_bit_cnt + 3'd1;
                        w_out_nxt = PREAMBLE[r_bit_cnt + 3'd1];
                    end else begin
                        // Hand over to the first data bit with no idle cycle.
                        w_state_nxt = ST_DATA;
                        w_bit_nxt   = '0;
                        w_pre_nxt   = 1'b0;
                        w_trig_nxt  = 1'b1;
                        w_lfsr_step = 1'b1;
                        w_out_nxt   = w_lfsr_out;
                    end
                end
            end
`endif

            ST_DATA: begin
                if (w_accept) begin
                    w_hold_nxt       = tx_data;
                    w_hold_last_nxt  = tx_last;
                    w_hold_valid_nxt = 1'b1;
                end
                if (!w_period_wrap) begin
                    w_period_nxt = r_period_cnt + CNT_W'(1);
                end else begin
                    w_period_nxt = '0;
                    if (r_bit_cnt != 3'd7) begin
                        w_bit_nxt   = r_bit_cnt + 3'd1;
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                        w_lfsr_step = 1'b1;
                        w_out_nxt   = w_lfsr_out;
                    end else if (r_cur_last) begin
                        w_state_nxt = ST_END;
                        w_trig_nxt  = 1'b0;
                        w_out_nxt   = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else if (w_next_avail) begin
                        // Seamless continuation: scrambler keeps running across bytes.
                        w_bit_nxt        = '0;
                        w_shift_nxt      = w_next_byte;
                        w_cur_last_nxt   = w_next_last;
                        w_hold_valid_nxt = 1'b0;
                        w_lfsr_step      = 1'b1;
                        w_out_nxt        = w_lfsr_out;
                    end else begin
                        w_state_nxt    = ST_IDLE;
                        w_trig_nxt     = 1'b0;
                        w_out_nxt      = 1'b0;
                        w_underrun_nxt = 1'b1;
                    end
                end
            end

            ST_END: begin
                w_state_nxt = ST_IDLE;
                w_trig_nxt  = 1'b0;
                w_out_nxt   = 1'b0;
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_trig_nxt  = 1'b0;
                w_out_nxt   = 1'b0;
            end
        endcase

        // A byte queued behind a last byte would belong to the next frame,
        // so the holding register is closed once the current byte is last.
        case (w_state_nxt)
            ST_IDLE: w_ready_nxt = 1'b1;
            ST_END:  w_ready_nxt = 1'b0;
            default: w_ready_nxt = !w_hold_valid_nxt && !w_cur_last_nxt;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_period_cnt <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_cur_last   <= 1'b0;
            r_hold       <= '0;
            r_hold_last  <= 1'b0;
            r_hold_valid <= 1'b0;
            r_tx_ready   <= 1'b0;
            r_out_data   <= 1'b0;
            r_trigger    <= 1'b0;
            r_done       <= 1'b0;
            r_underrun   <= 1'b0;
`ifdef WHITEN_PREAMBLE_EN
            r_preamble   <= 1'b0;
`endif
        end else begin
            r_period_cnt <= w_period_nxt;
            r_bit_cnt    <= w_bit_nxt;
            r_shift      <= w_shift_nxt;
            r_cur_last   <= w_cur_last_nxt;
            r_hold       <= w_hold_nxt;
            r_hold_last  <= w_hold_last_nxt;
            r_hold_valid <= w_hold_valid_nxt;
            r_tx_ready   <= w_ready_nxt;
            r_out_data   <= w_out_nxt;
            r_trigger    <= w_trig_nxt;
            r_done       <= w_done_nxt;
            r_underrun   <= w_underrun_nxt;
`ifdef WHITEN_PREAMBLE_EN
            r_preamble   <= w_pre_nxt;
`endif
        end
    end

    assign tx_ready     = r_tx_ready;
    assign output_data  = r_out_data;
    assign trigger_out  = r_trigger;
    assign busy         = (r_state != ST_IDLE);
    assign done         = r_done;
    assign underrun     = r_underrun;
    assign dbg_state    = r_state;
`ifdef WHITEN_PREAMBLE_EN
    assign preamble_out = r_preamble;
`else
    assign preamble_out = 1'b0;
`endif

endmodule
